// File: rtl/req_encoder_seq.sv
`default_nettype none
// ============================================================================
// req_encoder_seq : captures a multi-hot request word and streams out the
//                   index of each set bit, lowest index first.  Rev 1.0
// ============================================================================
module req_encoder_seq #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_in,
   input  logic                 req_valid,
   output logic                 req_ready,
   output logic [$clog2(N)-1:0] idx_out,
   output logic                 idx_valid,
   input  logic                 idx_ready,
   output logic [N-1:0]         pending,
   output logic                 busy
);

   localparam int W = $clog2(N);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [W-1:0]   idx_out_q, idx_out_d;
   logic           idx_valid_q, idx_valid_d;
   logic [N-1:0]   nxt;

   // Scanning from the top down leaves the lowest set index as the final winner.
   function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
      lowest_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = W'(i);
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      idx_out_d   = idx_out_q;
      idx_valid_d = idx_valid_q;
      nxt         = pending_q & ~({{(N-1){1'b0}}, 1'b1} << idx_out_q);
      case (state_q)
         IDLE: begin
            if (req_valid && (|req_in)) begin
               pending_d   = req_in;
               idx_out_d   = lowest_idx(req_in);
               idx_valid_d = 1'b1;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            if (idx_valid_q && idx_ready) begin
               pending_d = nxt;
               if (|nxt) begin
                  idx_out_d = lowest_idx(nxt);
               end else begin
                  idx_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         idx_out_q   <= '0;
         idx_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         idx_out_q   <= idx_out_d;
         idx_valid_q <= idx_valid_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q == DRAIN);
   assign idx_out   = idx_out_q;
   assign idx_valid = idx_valid_q;
   assign pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_req_encoder_seq.sv
`default_nettype none
// ============================================================================
// tb_req_encoder_seq : scoreboard bench for req_encoder_seq.  Rev 1.0
// ============================================================================
module tb_req_encoder_seq;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_in;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] idx_out;
   logic       idx_valid;
   logic       idx_ready;
   logic [3:0] pending;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] pend;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   req_encoder_seq #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .idx_out   (idx_out),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .pending   (pending),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs move #1 after the rising edge; the monitor looks at the falling
   // edge, so a visible valid&ready there is exactly the next edge's handshake.
   always @(negedge clk) begin
      if (rst_n && idx_valid && idx_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_idx: got idx=%0d pending=%b, none expected", idx_out, pending);
         end else begin
            mon_e = exp_q.pop_front();
            if (idx_out !== mon_e.idx || pending !== mon_e.pend) begin
               n_err++;
               $display("FAIL idx_stream: got idx=%0d pending=%b, want idx=%0d pending=%b",
                        idx_out, pending, mon_e.idx, mon_e.pend);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a cycle; queue up to 'limit' expected handshakes.
   task automatic send(input logic [3:0] v, input int limit);
      logic [3:0] p;
      int         pushed;
      exp_t       e;
      p      = v;
      pushed = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i] && pushed < limit) begin
            e.idx  = 2'(i);
            e.pend = p;
            exp_q.push_back(e);
            pushed++;
         end
         if (v[i]) p[i] = 1'b0;
      end
      check("req_ready_before_send", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_in    = v;
      tick();
      req_valid = 1'b0;
      req_in    = '0;
      check("idx_valid_after_accept", 32'(idx_valid), 32'(v != 4'd0));
   endtask

   task automatic drain(input bit rand_ready);
      int guard;
      guard = 0;
      while ((busy || exp_q.size() != 0) && guard < 200) begin
         if (rand_ready) idx_ready = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end
      check("drain_timeout", 32'(guard < 200), 32'd1);
      idx_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_in    = '0;
      req_valid = 1'b0;
      idx_ready = 1'b1;

      // Reset state
      repeat (2) tick();
      check("rst_idx_valid", 32'(idx_valid), 32'd0);
      check("rst_pending",   32'(pending),   32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      rst_n = 1'b1;
      repeat (5) begin
         tick();
         check("idle_no_output", 32'(idx_valid), 32'd0);
      end

      // 1011 at full throughput: 0,1,3 on consecutive cycles
      send(4'b1011, 4);
      check("t2_first_idx", 32'(idx_out), 32'd0);
      tick();
      check("t2_second_idx", 32'(idx_out), 32'd1);
      tick();
      check("t2_third_idx", 32'(idx_out), 32'd3);
      tick();
      check("t2_valid_low", 32'(idx_valid), 32'd0);
      check("t2_ready_back", 32'(req_ready), 32'd1);
      check("t2_pending_zero", 32'(pending), 32'd0);

      // Backpressure holds the first index
      idx_ready = 1'b0;
      send(4'b0110, 4);
      repeat (4) begin
         check("t3_hold_idx", 32'(idx_out), 32'd1);
         check("t3_hold_pending", 32'(pending), 32'h6);
         check("t3_hold_valid", 32'(idx_valid), 32'd1);
         tick();
      end
      idx_ready = 1'b1;
      tick();
      tick();
      check("t3_done", 32'(idx_valid), 32'd0);

      // Zero request is swallowed; inputs during drain are ignored
      send(4'b0000, 0);
      check("t4_zero_ready", 32'(req_ready), 32'd1);
      check("t4_zero_busy",  32'(busy),      32'd0);
      idx_ready = 1'b0;
      send(4'b0101, 4);
      req_valid = 1'b1;
      req_in    = 4'b1111;
      repeat (3) tick();
      check("t4_drain_ignore", 32'(pending), 32'h5);
      check("t4_ready_low", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      req_in    = '0;
      idx_ready = 1'b1;
      drain(1'b0);

      // Reset mid-drain: index 3 must never appear
      tick();
      send(4'b1100, 1);
      check("t5_first_idx", 32'(idx_out), 32'd2);
      tick();
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", 32'(idx_valid), 32'd0);
      check("t5_async_pending", 32'(pending), 32'd0);
      check("t5_async_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         check("t5_no_output", 32'(idx_valid), 32'd0);
      end

      // Every nonzero request with random downstream readiness
      for (int v = 1; v < 16; v++) begin
         send(4'(v), 4);
         drain(1'b1);
         tick();
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
